// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-memory access sequencer: runs one load/store at a time over a
// request/grant bus with variable latency, stalling the pipeline until it completes.
module dmem_access_ctrl #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic        StallMem,
    output logic [31:0] ReadDataM,
    output logic        MemErr,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        load_q, load_d;

    logic access;
    logic misaligned;
    logic timeout_hit;

    assign access      = MemtoRegM | MemWriteM;
    assign misaligned  = |ALUOutM[1:0];
    assign timeout_hit = (cnt_q == CNT_LAST);

    // NOTE: every flop uses non-blocking assignment and the async reset clears the
    // whole state, so a reset mid-access drops mem_req immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            load_q  <= load_d;
        end
    end

    // NOTE: every signal driven here is defaulted to its held value first, so no
    // branch can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        load_d  = load_q;
        unique case (state_q)
            IDLE: begin
                if (access) begin
                    load_d = MemtoRegM;
                    if (misaligned) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        if (MemtoRegM) rdata_d = '0;
                    end else begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        we_d    = ~MemtoRegM;
                        addr_d  = {ALUOutM[31:2], 2'b00};
                        wdata_d = WriteDataM;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                    end
                end
            end
            REQ: begin
                cnt_d = cnt_q + 8'd1;
                // A grant in the timeout cycle still completes the access.
                if (mem_gnt) begin
                    req_d   = 1'b0;
                    state_d = we_q ? DONE : WAIT;
                end else if (timeout_hit) begin
                    req_d   = 1'b0;
                    state_d = DONE;
                    err_d   = 1'b1;
                    if (load_q) rdata_d = '0;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_rvalid) begin
                    rdata_d = mem_rdata;
                    state_d = DONE;
                end else if (timeout_hit) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            DONE: begin
                // The instruction still presented is the one just finished.
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        StallMem = ((state_q == IDLE) && access) || (state_q == REQ) || (state_q == WAIT);
        MemErr   = (state_q == DONE) && err_q;
    end

    assign ReadDataM = rdata_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: a hand-driven memory bus answers each access
// with a chosen grant/rvalid delay and results are compared to hand-computed values.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemtoRegM = 1'b0;
    logic        MemWriteM = 1'b0;
    logic [31:0] ALUOutM = '0;
    logic [31:0] WriteDataM = '0;
    logic        StallMem;
    logic [31:0] ReadDataM;
    logic        MemErr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'hDEADBEEF;

    int checks = 0;
    int errors = 0;

    dmem_access_ctrl #(.TIMEOUT(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemtoRegM  (MemtoRegM),
        .MemWriteM  (MemWriteM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .StallMem   (StallMem),
        .ReadDataM  (ReadDataM),
        .MemErr     (MemErr),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one instruction, answers the bus after gnt_after non-granted REQ
    // cycles and rv_after empty WAIT cycles (negative = never), and stops in the
    // first non-stalled cycle. Leaves the bench one cycle later with no access.
    task automatic run_op(input logic ld, input logic st, input logic [31:0] addr,
                          input logic [31:0] wdata, input int gnt_after, input int rv_after,
                          input logic [31:0] rdata, output int stalls, output int reqs,
                          output logic err_seen, output logic [31:0] rd_done,
                          output int bus_bad);
        int  waits;
        bit  granted;
        bit  done;
        logic exp_we;
        exp_we = st & ~ld;
        MemtoRegM = ld; MemWriteM = st; ALUOutM = addr; WriteDataM = wdata;
        stalls = 0; reqs = 0; waits = 0; granted = 0; bus_bad = 0; done = 0;
        err_seen = 1'b0; rd_done = '0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hDEADBEEF;
            if (mem_req === 1'b1) begin
                if (mem_addr !== {addr[31:2], 2'b00} || mem_we !== exp_we) bus_bad++;
                if (exp_we && mem_wdata !== wdata) bus_bad++;
                if (reqs == gnt_after) begin
                    mem_gnt = 1'b1;
                    granted = 1;
                end
                reqs++;
            end else if (granted && ld) begin
                if (waits == rv_after) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = rdata;
                end
                waits++;
            end
            #1;
            if (StallMem === 1'b1) begin
                stalls++;
                @(posedge clk);
                #1;
            end else begin
                done     = 1;
                err_seen = MemErr;
                rd_done  = ReadDataM;
                if (mem_req !== 1'b0) bus_bad++;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL run_op_bound: access at %h still stalled after 100 cycles", addr);
        end
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        tick();
        MemtoRegM = 1'b0; MemWriteM = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++; if (ReadDataM !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", ReadDataM); end
        checks++; if ({MemErr, mem_req, mem_we} !== 3'b000) begin errors++; $display("FAIL reset_ctrl: got %b want 000", {MemErr, mem_req, mem_we}); end
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_bus: got %h/%h want 0/0", mem_addr, mem_wdata); end
        checks++; if (StallMem !== 1'b0) begin errors++; $display("FAIL reset_stall_idle: got %b want 0", StallMem); end
        MemtoRegM = 1'b1;
        #1;
        checks++; if (StallMem !== 1'b1) begin errors++; $display("FAIL reset_stall_access: got %b want 1", StallMem); end
        MemtoRegM = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_store();
        int s, r, bb; logic e; logic [31:0] rd;
        run_op(1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 0, -1, 32'h0, s, r, e, rd, bb);
        checks++; if (s != 2) begin errors++; $display("FAIL store_stall: got %0d want 2", s); end
        checks++; if (r != 1) begin errors++; $display("FAIL store_req: got %0d want 1", r); end
        checks++; if (bb != 0) begin errors++; $display("FAIL store_bus: got %0d bad cycles want 0", bb); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL store_err: got %b want 0", e); end
    endtask

    task automatic test_load_wait();
        int s, r, bb; logic e; logic [31:0] rd;
        run_op(1'b1, 1'b0, 32'h20, 32'h0, 3, 1, 32'h12345678, s, r, e, rd, bb);
        checks++; if (s != 7) begin errors++; $display("FAIL load_stall: got %0d want 7", s); end
        checks++; if (r != 4) begin errors++; $display("FAIL load_req: got %0d want 4", r); end
        checks++; if (bb != 0) begin errors++; $display("FAIL load_bus: got %0d bad cycles want 0", bb); end
        checks++; if (rd !== 32'h12345678 || e !== 1'b0) begin errors++; $display("FAIL load_done: got %h err %b want 12345678 err 0", rd, e); end
        checks++; if (ReadDataM !== 32'h12345678) begin errors++; $display("FAIL load_hold: got %h want 12345678", ReadDataM); end
    endtask

    task automatic test_misaligned();
        int s, r, bb; logic e; logic [31:0] rd;
        run_op(1'b1, 1'b0, 32'h22, 32'h0, 0, 0, 32'h77777777, s, r, e, rd, bb);
        checks++; if (s != 1 || r != 0) begin errors++; $display("FAIL misalign_stall: got stall %0d req %0d want 1/0", s, r); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL misalign_err: got %b want 1", e); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL misalign_rdata: got %h want 0", rd); end
        checks++; if (MemErr !== 1'b0) begin errors++; $display("FAIL misalign_pulse: got %b want 0 after DONE", MemErr); end
    endtask

    task automatic test_timeout();
        int s, r, bb; logic e; logic [31:0] rd;
        run_op(1'b1, 1'b0, 32'h40, 32'h0, 0, 0, 32'h55AA33CC, s, r, e, rd, bb);
        checks++; if (s != 3 || rd !== 32'h55AA33CC) begin errors++; $display("FAIL fast_load: got stall %0d data %h want 3/55aa33cc", s, rd); end
        run_op(1'b1, 1'b0, 32'h44, 32'h0, -1, -1, 32'h0, s, r, e, rd, bb);
        checks++; if (s != 16 || r != 15) begin errors++; $display("FAIL timeout_req: got stall %0d req %0d want 16/15", s, r); end
        checks++; if (e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL timeout_done: got err %b data %h want 1/0", e, rd); end
        mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'hFFFFFFFF;
        tick();
        mem_rvalid = 1'b0; mem_gnt = 1'b0;
        checks++; if (ReadDataM !== 32'h0 || mem_req !== 1'b0 || StallMem !== 1'b0) begin errors++; $display("FAIL late_rvalid: got data %h req %b stall %b want 0/0/0", ReadDataM, mem_req, StallMem); end
        run_op(1'b1, 1'b0, 32'h48, 32'h0, 0, -1, 32'h0, s, r, e, rd, bb);
        checks++; if (s != 16 || r != 1 || e !== 1'b1) begin errors++; $display("FAIL wait_timeout: got stall %0d req %0d err %b want 16/1/1", s, r, e); end
    endtask

    task automatic test_back_to_back();
        int s1, r1, b1, s2, r2, b2; logic e1, e2; logic [31:0] rd1, rd2;
        run_op(1'b0, 1'b1, 32'h80, 32'h11112222, 0, -1, 32'h0, s1, r1, e1, rd1, b1);
        run_op(1'b1, 1'b0, 32'h84, 32'h0, 0, 0, 32'h9ABCDEF0, s2, r2, e2, rd2, b2);
        checks++; if (s1 != 2 || s2 != 3) begin errors++; $display("FAIL b2b_stall: got %0d/%0d want 2/3", s1, s2); end
        checks++; if (r1 != 1 || r2 != 1 || b1 != 0 || b2 != 0) begin errors++; $display("FAIL b2b_req: got req %0d/%0d bad %0d/%0d want 1/1 0/0", r1, r2, b1, b2); end
        checks++; if (rd2 !== 32'h9ABCDEF0 || e1 !== 1'b0 || e2 !== 1'b0) begin errors++; $display("FAIL b2b_data: got %h err %b%b want 9abcdef0 err 00", rd2, e1, e2); end
    endtask

    task automatic test_reset_mid_access();
        int s, r, bb; logic e; logic [31:0] rd;
        MemtoRegM = 1'b1; ALUOutM = 32'h60;
        tick();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_req_pre: got %b want 1", mem_req); end
        rst_n = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_req_drop: got %b want 0", mem_req); end
        #2;
        rst_n = 1'b1;
        tick();
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        checks++; if (StallMem !== 1'b1 || mem_req !== 1'b0) begin errors++; $display("FAIL rst_wait_pre: got stall %b req %b want 1/0", StallMem, mem_req); end
        rst_n = 1'b0;
        #1;
        MemtoRegM = 1'b0;
        #1;
        checks++; if (StallMem !== 1'b0 || ReadDataM !== 32'h0 || mem_req !== 1'b0) begin errors++; $display("FAIL rst_wait_clear: got stall %b data %h req %b want 0/0/0", StallMem, ReadDataM, mem_req); end
        tick();
        rst_n = 1'b1;
        tick();
        run_op(1'b1, 1'b0, 32'h64, 32'h0, 0, 0, 32'h0F0F0F0F, s, r, e, rd, bb);
        checks++; if (s != 3 || r != 1 || rd !== 32'h0F0F0F0F || bb != 0) begin errors++; $display("FAIL rst_restart: got stall %0d req %0d data %h bad %0d want 3/1/0f0f0f0f/0", s, r, rd, bb); end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load_wait();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Sequences MEM-stage data-memory accesses of the 5-stage MIPS pipeline onto a variable-latency, request/grant data-memory bus. It sits between the EX/MEM pipeline register outputs (ALUOutM, WriteDataM, MemtoRegM, MemWriteM) and the data memory. It stalls the pipeline while an access is outstanding. It returns load data to the MEM/WB register and flags misaligned or timed-out accesses.

## Interface
Parameters:
- TIMEOUT, 15: maximum cycles spent in REQ+WAIT before the access is aborted (range 1..255).

Ports:
- clk  in  1  pipeline clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- MemtoRegM  in  1  MEM-stage instruction is a load (lw)
- MemWriteM  in  1  MEM-stage instruction is a store (sw)
- ALUOutM  in  32  byte address of the access
- WriteDataM  in  32  store data
- StallMem  out  1  freeze PC, IF/ID, ID/EX and EX/MEM registers; bubble MEM/WB
- ReadDataM  out  32  registered load data for MEM/WB
- MemErr  out  1  one-cycle pulse on misaligned or timed-out access
- mem_req  out  1  bus request
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  32  word-aligned address; valid while mem_req
- mem_wdata  out  32  write data; valid while mem_req
- mem_gnt  in  1  bus accepts the request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data

## Operation
- access = MemtoRegM | MemWriteM. If both are 1, treat as a load.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - access with ALUOutM[1:0]==0: latch addr/we/wdata, then go to REQ.
  - access with ALUOutM[1:0]!=0: go to DONE with err=1 and no bus request.
  - No access: stay in IDLE.
- REQ: mem_req=1, outputs driven from the latched registers.
  - mem_gnt on a store: go to DONE.
  - mem_gnt on a load: go to WAIT.
- WAIT: mem_rvalid captures mem_rdata into ReadDataM, then go to DONE.
- Timeout counter:
  - Cleared on entry to REQ; increments every cycle in REQ or WAIT.
  - When it reaches TIMEOUT-1 without the exit condition, go to DONE with err=1.
  - A grant or rvalid arriving in that same cycle wins; no error is raised.
- DONE:
  - MemErr = err.
  - On err for a load, ReadDataM = 0.
  - Always returns to IDLE; never starts a new access, because the instruction still presented is the one just completed.
- StallMem = (IDLE & access) | REQ | WAIT. It is combinational and deasserted in DONE, so the pipeline advances at the end of DONE.
- mem_rvalid outside WAIT and mem_gnt outside REQ are ignored.
- ReadDataM holds its value except at a WAIT capture or a DONE error on a load.

## Timing
- Reset (async, rst_n=0):
  - State = IDLE.
  - ReadDataM=0, MemErr=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, counter=0.
  - StallMem follows access combinationally.
- Reset mid-access: mem_req drops immediately; the pending transfer is abandoned.
- mem_req, mem_we, mem_addr and mem_wdata are registered and held stable from REQ entry until the grant cycle.
- Store with grant in the first REQ cycle: stall cycles IDLE, REQ (2), then DONE.
- Load with grant in the first REQ cycle and rvalid the next cycle: 3 stall cycles, then ReadDataM valid in DONE and thereafter.
- Misaligned access: 1 stall cycle (IDLE), then DONE with the MemErr pulse.
- Back-to-back accesses: DONE is followed by IDLE, which sees the next MEM instruction; at most one access is outstanding.
- Timeout with TIMEOUT=15: at most 1 + 15 stall cycles.

## Test plan
- sw, ALUOutM=0x10, WriteDataM=0xCAFEF00D, grant on the first REQ cycle -> mem_req=1, mem_we=1, mem_addr=0x10, mem_wdata=0xCAFEF00D for 1 cycle; StallMem high for 2 cycles; MemErr=0.
- lw, ALUOutM=0x20, grant after 3 REQ cycles, rvalid 2 cycles later with mem_rdata=0x12345678 -> StallMem high for 7 cycles; ReadDataM=0x12345678 in DONE.
- lw, ALUOutM=0x22 -> no mem_req; StallMem 1 cycle; MemErr pulse in the next cycle; ReadDataM=0.
- lw with no grant, TIMEOUT=15 -> mem_req high for 15 cycles, then DONE with MemErr=1 and ReadDataM=0; a late mem_rvalid is ignored.
- Back-to-back sw then lw, both granted immediately, rvalid one cycle later -> exactly one request per instruction; one DONE cycle separates the two.
- rst_n asserted while in WAIT -> mem_req and StallMem-internal state clear asynchronously; ReadDataM=0; the next lw starts cleanly from IDLE.
